registers_bank_sb: RTL
======================

Name: registers_bank_sb

Overview:
Parametrised successor to the 4x16 register bank.
- Configurable width and depth, two asynchronous read ports with same-cycle write bypass, and an optional hard-wired zero register.
- Per-register busy scoreboard for the datapath control unit: reserve on issue, clear on writeback.
- Handshaked sequential dump engine that streams every register out for debug and verification.

Parameters:
size_reg, 16, data width of each register in bits
addr_reg, 2, address width; depth = 2**addr_reg
zero_reg, 0, when 1, register 0 always reads 0 and ignores writes and reserves

Ports:
clock  input  1  single system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; sampled on rising edge of clock
addr_A  input  addr_reg  read port A address
addr_B  input  addr_reg  read port B address
data_A  output  size_reg  read port A data (combinational)
data_B  output  size_reg  read port B data (combinational)
busy_A  output  1  scoreboard bit of addr_A
busy_B  output  1  scoreboard bit of addr_B
write_reg  input  1  write enable
addr_R  input  addr_reg  write address
write_data  input  size_reg  write data
reserve  input  1  reserve request for addr_D
addr_D  input  addr_reg  destination being reserved
reserve_ok  output  1  combinational grant for the current reserve request
dump_start  input  1  start a dump (ignored unless idle)
dump_valid  output  1  dump_data/dump_addr valid
dump_ready  input  1  consumer accepts current dump word
dump_addr  output  addr_reg  index of the word being dumped
dump_data  output  size_reg  contents of registers[dump_addr]
dump_done  output  1  one-cycle pulse after the last word is accepted

Behaviour:
- Reset (synchronous, high at rising edge):
  - All registers and busy bits go to 0.
  - Dump FSM goes to IDLE, index to 0; dump_valid and dump_done go to 0.
  - Reset overrides write, reserve and dump in the same cycle.
- Write: if write_reg, registers[addr_R] <= write_data at the edge. If zero_reg=1 and addr_R=0, the write is dropped.
- Read: data_X = registers[addr_X], with these overrides:
  - If write_reg and addr_R==addr_X, data_X = write_data (bypass).
  - If zero_reg=1 and addr_X=0, data_X = 0; this takes priority over bypass.
- busy_X = busy[addr_X], combinational from the registered busy bits. The bypass does not affect busy_X.
- Scoreboard grant: reserve_ok = reserve & (~busy[addr_D] | (write_reg & addr_R==addr_D)).
  - reserve_ok is forced to 0 when zero_reg=1 and addr_D=0.
- Scoreboard next state, per register i:
  - Set if reserve_ok and addr_D==i.
  - Else clear if write_reg and addr_R==i.
  - Else hold.
  - Reserve and writeback to the same register in one cycle leave busy=1.
  - A refused reserve changes nothing.
- Dump FSM, states IDLE and STREAM:
  - IDLE: dump_valid=0. dump_start moves the FSM to STREAM next cycle with index=0.
  - STREAM: dump_valid=1, dump_addr=index, dump_data = registers[index] (live contents, no bypass; zero-reg rule applies).
    - Accept (valid & ready) with index<depth-1: index+1.
    - Accept with index==depth-1: go to IDLE, index=0, dump_done=1 for exactly one cycle.
    - No accept: dump_addr and dump_data hold.
  - dump_start during STREAM is ignored.
  - Writes and reserves stay fully functional during a dump. A word reflects register contents at the cycle it is accepted.
  - Minimum dump length is depth cycles; back-to-back restart is possible the cycle after dump_done.
- Latency:
  - Writes are visible on the read ports in the same cycle via bypass, and from the register array the next cycle.
  - Busy bits update one cycle after reserve or writeback.

Decomposition:
- Shared package regbank_pkg holds:
  - dump_state_t enum: IDLE, STREAM.
  - Defaults REG_W=16 and REG_AW=2.
- One sub-module, regbank_scoreboard, is natural: busy vector, grant logic, set/clear priority.
- The register array, read/bypass muxing and dump FSM stay in the top module.

Test Plan:
- Reset, then read all addresses -> data_A=data_B=0, busy_A=busy_B=0, dump_valid=0.
- Write 16'hBEEF to R2 with addr_A=2 in the same cycle -> data_A=16'hBEEF that cycle (bypass) and after; zero_reg=1, write 16'h1234 to R0 -> reads 0.
- Reserve R1 -> reserve_ok=1, busy_B=1 next cycle (addr_B=1). Reserve R1 again -> reserve_ok=0. Write R1 with reserve R1 in the same cycle -> reserve_ok=1, busy stays 1. Write R1 alone -> busy 0.
- Load R0..R3 with 1,2,3,4, pulse dump_start, dump_ready=1 -> dump_addr 0,1,2,3 with data 1,2,3,4 on consecutive cycles, dump_done pulses once, FSM back in IDLE.
- Dump with dump_ready toggling 0/1 and a write of 16'h00AA to R3 before index 3 is accepted -> words hold while ready=0, R3 dumps as 16'h00AA, dump_start mid-stream has no effect.
- Assert reset during STREAM at index 2 with R1 busy -> next cycle dump_valid=0, all busy bits 0, all registers 0; a new dump_start restarts from index 0.

Source files
------------

// File: rtl/registers_bank_sb_pkg.sv
// Shared types and defaults for the register bank with scoreboard and dump engine.
package regbank_pkg;

    localparam int REG_W  = 16;
    localparam int REG_AW = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } dump_state_t;

endpackage

// File: rtl/registers_bank_sb_if.sv
// Bus bundle for the register bank: read ports, write port, scoreboard reserve and dump stream.
// Dump handshake: a word transfers on a rising edge where dump_valid and dump_ready are both
// high; while dump_valid is high and dump_ready is low, dump_addr and dump_data hold, and
// dump_valid never drops without a transfer except on reset.
interface registers_bank_sb_if #(
    parameter int W  = 16,
    parameter int AW = 2
);
    logic [AW-1:0] addr_A;
    logic [AW-1:0] addr_B;
    logic [W-1:0]  data_A;
    logic [W-1:0]  data_B;
    logic          busy_A;
    logic          busy_B;
    logic          write_reg;
    logic [AW-1:0] addr_R;
    logic [W-1:0]  write_data;
    logic          reserve;
    logic [AW-1:0] addr_D;
    logic          reserve_ok;
    logic          dump_start;
    logic          dump_valid;
    logic          dump_ready;
    logic [AW-1:0] dump_addr;
    logic [W-1:0]  dump_data;
    logic          dump_done;

    modport master (
        output addr_A, addr_B, write_reg, addr_R, write_data, reserve, addr_D,
               dump_start, dump_ready,
        input  data_A, data_B, busy_A, busy_B, reserve_ok, dump_valid, dump_addr,
               dump_data, dump_done
    );

    modport slave (
        input  addr_A, addr_B, write_reg, addr_R, write_data, reserve, addr_D,
               dump_start, dump_ready,
        output data_A, data_B, busy_A, busy_B, reserve_ok, dump_valid, dump_addr,
               dump_data, dump_done
    );
endinterface

// File: rtl/registers_bank_sb_scoreboard.sv
// Per-register busy scoreboard: reserve on issue, clear on writeback, reserve wins a tie.
module regbank_scoreboard
    import regbank_pkg::*;
#(
    parameter int addr_reg = REG_AW,
    parameter int zero_reg = 0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                write_reg,
    input  logic [addr_reg-1:0] addr_R,
    input  logic                reserve,
    input  logic [addr_reg-1:0] addr_D,
    input  logic [addr_reg-1:0] addr_A,
    input  logic [addr_reg-1:0] addr_B,
    output logic                busy_A,
    output logic                busy_B,
    output logic                reserve_ok
);
    localparam int DEPTH = 1 << addr_reg;

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic             wb_same;
    logic             d_is_zero;

    assign wb_same    = write_reg && (addr_R == addr_D);
    assign d_is_zero  = (zero_reg != 0) && (addr_D == '0);
    // A busy destination can still be granted when its writeback lands this same cycle.
    assign reserve_ok = reserve && (!busy_q[addr_D] || wb_same) && !d_is_zero;
    assign busy_A     = busy_q[addr_A];
    assign busy_B     = busy_q[addr_B];

    // Next busy vector: set on grant, otherwise clear on writeback, otherwise hold.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (reserve_ok && (addr_D == addr_reg'(i))) begin
                busy_d[i] = 1'b1;
            end else if (write_reg && (addr_R == addr_reg'(i))) begin
                busy_d[i] = 1'b0;
            end
        end
    end

    // Busy register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/registers_bank_sb.sv
// Parametrised register bank: two bypassed read ports, optional zero register,
// busy scoreboard and a handshaked sequential dump engine.
module registers_bank_sb
    import regbank_pkg::*;
#(
    parameter int size_reg = REG_W,
    parameter int addr_reg = REG_AW,
    parameter int zero_reg = 0
) (
    input  logic        clock,
    input  logic        reset,
    registers_bank_sb_if.slave bus,
    output dump_state_t dbg_state_o
);
    localparam int                  DEPTH = 1 << addr_reg;
    localparam logic [addr_reg-1:0] LAST  = addr_reg'(DEPTH - 1);

    logic [size_reg-1:0] regs_q [DEPTH];
    logic                wr_en;
    logic [size_reg-1:0] rd_a;
    logic [size_reg-1:0] rd_b;
    logic [size_reg-1:0] dump_word;

    dump_state_t         state_q, state_d;
    logic [addr_reg-1:0] idx_q, idx_d;
    logic                done_q, done_d;
    logic                accept;

    // Writes to a hard-wired zero register are dropped.
    assign wr_en = bus.write_reg && !((zero_reg != 0) && (bus.addr_R == '0));

    // Register array with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[bus.addr_R] <= bus.write_data;
        end
    end

    // Read port A: bypass the in-flight write, zero register overrides the bypass.
    always_comb begin
        rd_a = regs_q[bus.addr_A];
        if (bus.write_reg && (bus.addr_R == bus.addr_A)) rd_a = bus.write_data;
        if ((zero_reg != 0) && (bus.addr_A == '0))       rd_a = '0;
    end

    // Read port B: same rules as port A.
    always_comb begin
        rd_b = regs_q[bus.addr_B];
        if (bus.write_reg && (bus.addr_R == bus.addr_B)) rd_b = bus.write_data;
        if ((zero_reg != 0) && (bus.addr_B == '0))       rd_b = '0;
    end

    // Dump word comes from live array contents, without bypass.
    always_comb begin
        dump_word = regs_q[idx_q];
        if ((zero_reg != 0) && (idx_q == '0)) dump_word = '0;
    end

    assign bus.data_A = rd_a;
    assign bus.data_B = rd_b;

    regbank_scoreboard #(
        .addr_reg (addr_reg),
        .zero_reg (zero_reg)
    ) u_scoreboard (
        .clock      (clock),
        .reset      (reset),
        .write_reg  (bus.write_reg),
        .addr_R     (bus.addr_R),
        .reserve    (bus.reserve),
        .addr_D     (bus.addr_D),
        .addr_A     (bus.addr_A),
        .addr_B     (bus.addr_B),
        .busy_A     (bus.busy_A),
        .busy_B     (bus.busy_B),
        .reserve_ok (bus.reserve_ok)
    );

    assign accept = (state_q == STREAM) && bus.dump_ready;

    // Dump FSM next state: start from IDLE, step the index on each accepted word.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.dump_start) begin
                    state_d = STREAM;
                    idx_d   = '0;
                end
            end
            STREAM: begin
                if (accept) begin
                    if (idx_q == LAST) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Dump FSM state, index and completion pulse registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    assign bus.dump_valid = (state_q == STREAM);
    assign bus.dump_addr  = idx_q;
    assign bus.dump_data  = dump_word;
    assign bus.dump_done  = done_q;
    assign dbg_state_o    = state_q;

endmodule
